// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// UART receiver. Oversamples the serial line on i_ce and deserialises
// LSB-first frames of 6..9 data bits. It checks an optional parity bit and the
// stop bit, then hands each word to the bus side through a level-valid /
// read-strobe handshake. Overrun reporting is sticky.
//
// Ports:
//   i_clk         clock
//   i_rst         asynchronous, active-high reset
//   i_ce          oversample tick, OVERSAMPLE ticks per bit period
//   i_rx          serial line (asynchronous, idles high)
//   i_length      data bits = i_length + 6
//   i_parity      a parity bit follows the data bits
//   i_odd         odd parity when 1, even parity when 0
//   i_read        one-cycle strobe: the consumer took o_data
//   o_data        received word, right-justified, unused upper bits 0
//   o_valid       o_data holds an unread word
//   o_parity_err  parity error for the word in o_data
//   o_frame_err   stop bit was sampled low for the word in o_data
//   o_overrun     sticky: a word completed while o_valid was already set
//   o_busy        frame reception in progress
//
// Handshake: o_valid is a level that stays high until the consumer pulses
// i_read for one cycle. The word in o_data is stable while o_valid is high,
// unless a newer word overwrites it; that case also raises o_overrun. An
// i_read pulse has no effect while o_valid is low.
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ce,
    input  logic       i_rx,
    input  logic [1:0] i_length,
    input  logic       i_parity,
    input  logic       i_odd,
    input  logic       i_read,
    output logic [8:0] o_data,
    output logic       o_valid,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_busy
);

    localparam logic [3:0] T_MID = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] T_END = 4'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_SHIFT  = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t     r_state;
    logic       r_rx_meta;
    logic       r_rx_s;
    logic [3:0] r_tcnt;
    logic [3:0] r_bcnt;
    logic [8:0] r_shreg;
    logic       r_pbit;
    logic [1:0] r_len;
    logic       r_par;
    logic       r_odd;

    logic [8:0] w_data;
    logic       w_perr;

    // Bits enter at shreg[8] and shift right. After N samples the word sits in
    // the top N bits, so shifting right by 9-N = 3-len right-justifies it. The
    // same shift pushes any stale low bits out.
    assign w_data = r_shreg >> (2'd3 - r_len);
    assign w_perr = r_par & (^w_data ^ r_pbit ^ r_odd);

    // Two-flop synchroniser. It resets to the idle line level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_tcnt       <= 4'd0;
            r_bcnt       <= 4'd0;
            r_shreg      <= 9'd0;
            r_pbit       <= 1'b0;
            r_len        <= 2'd0;
            r_par        <= 1'b0;
            r_odd        <= 1'b0;
            o_data       <= 9'd0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            if (i_read && o_valid) begin
                o_valid   <= 1'b0;
                o_overrun <= 1'b0;
            end

            if (i_ce) begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_rx_s) begin
                            r_state <= S_START;
                            o_busy  <= 1'b1;
                            r_tcnt  <= 4'd0;
                            // Configuration is latched once per frame.
                            r_len   <= i_length;
                            r_par   <= i_parity;
                            r_odd   <= i_odd;
                        end
                    end

                    S_START: begin
                        if (r_tcnt == T_MID) begin
                            r_tcnt <= 4'd0;
                            if (r_rx_s) begin
                                // The line is high again by mid start bit,
                                // so this was a glitch. Drop it silently.
                                r_state <= S_IDLE;
                                o_busy  <= 1'b0;
                            end else begin
                                r_state <= S_SHIFT;
                                r_bcnt  <= 4'(r_len) + 4'd5;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + 4'd1;
                        end
                    end

                    S_SHIFT: begin
                        if (r_tcnt == T_END) begin
                            r_tcnt  <= 4'd0;
                            r_shreg <= {r_rx_s, r_shreg[8:1]};
                            if (r_bcnt == 4'd0) begin
                                r_state <= r_par ? S_PARITY : S_STOP;
                            end else begin
                                r_bcnt <= r_bcnt - 4'd1;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + 4'd1;
                        end
                    end

                    S_PARITY: begin
                        if (r_tcnt == T_END) begin
                            r_tcnt  <= 4'd0;
                            r_pbit  <= r_rx_s;
                            r_state <= S_STOP;
                        end else begin
                            r_tcnt <= r_tcnt + 4'd1;
                        end
                    end

                    S_STOP: begin
                        if (r_tcnt == T_END) begin
                            // Return to idle at mid stop bit. This leaves
                            // half a bit of slack to catch a back-to-back
                            // start edge.
                            r_tcnt       <= 4'd0;
                            r_state      <= S_IDLE;
                            o_busy       <= 1'b0;
                            o_data       <= w_data;
                            o_parity_err <= w_perr;
                            o_frame_err  <= ~r_rx_s;
                            o_valid      <= 1'b1;
                            if (o_valid && !i_read) begin
                                o_overrun <= 1'b1;
                            end
                        end else begin
                            r_tcnt <= r_tcnt + 4'd1;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        o_busy  <= 1'b0;
                        r_tcnt  <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Directed bench for uart_rx with OVERSAMPLE = 16. i_ce fires every 4 clocks,
// so one bit period lasts 64 clocks. Inputs change on the falling clock edge,
// and outputs are sampled there as well.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int OS       = 16;
    localparam int CE_DIV   = 4;
    localparam int BIT_CLKS = OS * CE_DIV;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_ce;
    logic       i_rx;
    logic [1:0] i_length;
    logic       i_parity;
    logic       i_odd;
    logic       i_read;
    logic [8:0] o_data;
    logic       o_valid;
    logic       o_parity_err;
    logic       o_frame_err;
    logic       o_overrun;
    logic       o_busy;

    int n_vec = 0;
    int n_err = 0;

    uart_rx #(.OVERSAMPLE(OS)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_ce         (i_ce),
        .i_rx         (i_rx),
        .i_length     (i_length),
        .i_parity     (i_parity),
        .i_odd        (i_odd),
        .i_read       (i_read),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_parity_err (o_parity_err),
        .o_frame_err  (o_frame_err),
        .o_overrun    (o_overrun),
        .o_busy       (o_busy)
    );

    // Clock and clock-enable generation.
    always #5 i_clk = ~i_clk;

    initial begin
        int ce_cnt;
        ce_cnt = 0;
        i_ce   = 1'b0;
        forever begin
            @(negedge i_clk);
            ce_cnt = (ce_cnt + 1) % CE_DIV;
            i_ce   = (ce_cnt == 0);
        end
    end

    // Comparison helpers.
    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [8:0] data, input logic valid,
                             input logic perr, input logic ferr, input logic ovr,
                             input logic busy);
        check({tag, ".data"},  o_data,              data);
        check({tag, ".valid"}, {8'd0, o_valid},      {8'd0, valid});
        check({tag, ".perr"},  {8'd0, o_parity_err}, {8'd0, perr});
        check({tag, ".ferr"},  {8'd0, o_frame_err},  {8'd0, ferr});
        check({tag, ".ovr"},   {8'd0, o_overrun},    {8'd0, ovr});
        check({tag, ".busy"},  {8'd0, o_busy},       {8'd0, busy});
    endtask

    // Line driver tasks.
    task automatic send_bit(input logic b);
        i_rx = b;
        repeat (BIT_CLKS) @(negedge i_clk);
    endtask

    task automatic send_frame(input logic [8:0] data, input int nbits, input logic par_en,
                              input logic pbit, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(data[i]);
        if (par_en) send_bit(pbit);
        send_bit(stop);
        i_rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        i_rx = 1'b1;
        repeat (n * BIT_CLKS) @(negedge i_clk);
    endtask

    task automatic do_read();
        i_read = 1'b1;
        @(negedge i_clk);
        i_read = 1'b0;
        @(negedge i_clk);
    endtask

    initial begin
        i_rst    = 1'b1;
        i_rx     = 1'b1;
        i_length = 2'd2;
        i_parity = 1'b0;
        i_odd    = 1'b0;
        i_read   = 1'b0;

        // Reset state.
        repeat (3) @(negedge i_clk);
        check_out("reset", 9'h000, 0, 0, 0, 0, 0);
        i_rst = 1'b0;
        idle_bits(1);
        check_out("post_reset", 9'h000, 0, 0, 0, 0, 0);

        // 8N1, 0xA5.
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1);
        check_out("8n1_a5", 9'h0A5, 1, 0, 0, 0, 0);
        do_read();
        check("8n1_read_valid", {8'd0, o_valid}, 9'd0);

        // 7E1, 0x41 (two ones, so the even parity bit is 0).
        i_length = 2'd1;
        i_parity = 1'b1;
        i_odd    = 1'b0;
        idle_bits(1);
        send_frame(9'h041, 7, 1'b1, 1'b0, 1'b1);
        check_out("7e1_good", 9'h041, 1, 0, 0, 0, 0);
        do_read();
        send_frame(9'h041, 7, 1'b1, 1'b1, 1'b1);
        check_out("7e1_bad", 9'h041, 1, 1, 0, 0, 0);
        do_read();

        // 7O1, 0x41: the correct odd parity bit is 1.
        i_odd = 1'b1;
        send_frame(9'h041, 7, 1'b1, 1'b1, 1'b1);
        check_out("7o1_good", 9'h041, 1, 0, 0, 0, 0);
        do_read();

        // 6-bit word 0x2C with the stop bit held low.
        i_length = 2'd0;
        i_parity = 1'b0;
        i_odd    = 1'b0;
        send_frame(9'h02C, 6, 1'b0, 1'b0, 1'b0);
        idle_bits(2);
        check_out("6n1_ferr", 9'h02C, 1, 0, 1, 0, 0);
        do_read();

        // 4-tick low glitch on the idle line.
        i_rx = 1'b0;
        repeat (4 * CE_DIV) @(negedge i_clk);
        check("glitch_busy", {8'd0, o_busy}, 9'd1);
        i_rx = 1'b1;
        repeat (BIT_CLKS) @(negedge i_clk);
        check_out("glitch_end", 9'h02C, 0, 0, 1, 0, 0);

        // Back-to-back 8N1 frames with no read in between.
        i_length = 2'd2;
        send_frame(9'h011, 8, 1'b0, 1'b0, 1'b1);
        send_frame(9'h022, 8, 1'b0, 1'b0, 1'b1);
        check_out("b2b", 9'h022, 1, 0, 0, 1, 0);
        do_read();
        check_out("b2b_read", 9'h022, 0, 0, 0, 0, 0);

        // Asynchronous reset during S_SHIFT while an unread word is held.
        idle_bits(1);
        send_frame(9'h033, 8, 1'b0, 1'b0, 1'b1);
        check("pre_rst_valid", {8'd0, o_valid}, 9'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        check("pre_rst_busy", {8'd0, o_busy}, 9'd1);
        #2;
        i_rst = 1'b1;
        #1;
        check_out("async_rst", 9'h000, 0, 0, 0, 0, 0);
        i_rx = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        idle_bits(1);
        check_out("rst_idle", 9'h000, 0, 0, 0, 0, 0);
        send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b1);
        check_out("after_rst_5a", 9'h05A, 1, 0, 0, 0, 0);
        do_read();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
